instruction_decoder: RTL and testbench

- Instruction-decode (ID) stage of the vector pipeline.
- Splits a 32-bit instruction into register-file read addresses, hazard-unit source addresses, ALU controls, branch controls, memory controls and write-back controls.
- Decode is combinational; every output is registered, so results appear one cycle after the instruction is presented.
- Outputs feed the register file, hazard detection unit (HDU), EX stage and memory stage.

---
 rtl/instruction_decoder.sv | 142 ++++++++++++++
 tb/tb_instruction_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// ID stage of the vector pipeline: decodes one 32-bit instruction into register, hazard,
// ALU, branch, memory and write-back controls. All results are registered (1-cycle latency).
module instruction_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instruction,
    output logic [4:0]  RegisterA,
    output logic [4:0]  RegisterB,
    output logic [4:0]  WW,
    output logic [5:0]  operation,
    output logic [4:0]  arithmatic_RD,
    output logic [4:0]  HDU_A,
    output logic [4:0]  HDU_B,
    output logic [1:0]  BR,
    output logic [15:0] Branch_immediate,
    output logic [15:0] MEM_addr,
    output logic        store_Enable,
    output logic        mem_Enable,
    output logic        writen_en,
    output logic        load_signal
);

    typedef enum logic [5:0] {
        OP_VLD   = 6'b100000,
        OP_VSD   = 6'b100001,
        OP_VBEZ  = 6'b100010,
        OP_VBNEZ = 6'b100011,
        OP_RTYPE = 6'b101010,
        OP_VNOP  = 6'b111100
    } opcode_e;

    typedef enum logic [1:0] {
        BR_NONE  = 2'b00,
        BR_VBEZ  = 2'b01,
        BR_VBNEZ = 2'b10
    } branch_e;

    typedef struct packed {
        logic [4:0]  reg_a;
        logic [4:0]  reg_b;
        logic [4:0]  ww;
        logic [5:0]  operation;
        logic [4:0]  rd;
        logic [4:0]  hdu_a;
        logic [4:0]  hdu_b;
        branch_e     br;
        logic [15:0] br_imm;
        logic [15:0] mem_addr;
        logic        store_en;
        logic        mem_en;
        logic        wr_en;
        logic        load;
    } decode_t;

    logic [5:0]  f_op;
    logic [4:0]  f_rd;
    logic [4:0]  f_ra;
    logic [4:0]  f_rb;
    logic [4:0]  f_w;
    logic [5:0]  f_func;
    logic [15:0] f_imm;

    decode_t dec_next;
    decode_t dec_q;

    assign f_op   = instruction[31:26];
    assign f_rd   = instruction[25:21];
    assign f_ra   = instruction[20:16];
    assign f_rb   = instruction[15:11];
    assign f_w    = instruction[10:6];
    assign f_func = instruction[5:0];
    assign f_imm  = instruction[15:0];

    always_comb begin
        // NOTE: defaulting the whole struct first keeps every path assigned, so no latch is inferred.
        dec_next = '0;
        case (f_op)
            OP_RTYPE: begin
                dec_next.reg_a     = f_ra;
                dec_next.hdu_a     = f_ra;
                dec_next.reg_b     = f_rb;
                dec_next.hdu_b     = f_rb;
                dec_next.ww        = f_w;
                dec_next.operation = f_func;
                dec_next.rd        = f_rd;
                dec_next.wr_en     = 1'b1;
            end
            OP_VLD: begin
                dec_next.rd       = f_rd;
                dec_next.mem_addr = f_imm;
                dec_next.mem_en   = 1'b1;
                dec_next.wr_en    = 1'b1;
                dec_next.load     = 1'b1;
            end
            OP_VSD: begin
                // The store data register travels in the rD slot.
                dec_next.reg_a    = f_rd;
                dec_next.hdu_a    = f_rd;
                dec_next.mem_addr = f_imm;
                dec_next.mem_en   = 1'b1;
                dec_next.store_en = 1'b1;
            end
            OP_VBEZ, OP_VBNEZ: begin
                dec_next.reg_a  = f_rd;
                dec_next.hdu_a  = f_rd;
                dec_next.br_imm = f_imm;
                dec_next.br     = (f_op == OP_VBEZ) ? BR_VBEZ : BR_VBNEZ;
            end
            OP_VNOP: ;
            default: ;
        endcase
    end

    // Flush wins over stall so a squashed slot can never be held.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments here so all registers update together at the edge.
        if (reset)
            dec_q <= '0;
        else if (flush)
            dec_q <= '0;
        else if (!stall)
            dec_q <= dec_next;
    end

    assign RegisterA        = dec_q.reg_a;
    assign RegisterB        = dec_q.reg_b;
    assign WW               = dec_q.ww;
    assign operation        = dec_q.operation;
    assign arithmatic_RD    = dec_q.rd;
    assign HDU_A            = dec_q.hdu_a;
    assign HDU_B            = dec_q.hdu_b;
    assign BR               = dec_q.br;
    assign Branch_immediate = dec_q.br_imm;
    assign MEM_addr         = dec_q.mem_addr;
    assign store_Enable     = dec_q.store_en;
    assign mem_Enable       = dec_q.mem_en;
    assign writen_en        = dec_q.wr_en;
    assign load_signal      = dec_q.load;

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: directed vectors push hand-computed expectations,
// a monitor compares them against the registered outputs after each clock or reset edge.
module tb_instruction_decoder;

    typedef struct packed {
        logic [4:0]  reg_a;
        logic [4:0]  reg_b;
        logic [4:0]  ww;
        logic [5:0]  operation;
        logic [4:0]  rd;
        logic [4:0]  hdu_a;
        logic [4:0]  hdu_b;
        logic [1:0]  br;
        logic [15:0] br_imm;
        logic [15:0] mem_addr;
        logic        store_en;
        logic        mem_en;
        logic        wr_en;
        logic        load;
    } dec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instruction = '0;
    logic [4:0]  RegisterA, RegisterB, WW, arithmatic_RD, HDU_A, HDU_B;
    logic [5:0]  operation;
    logic [1:0]  BR;
    logic [15:0] Branch_immediate, MEM_addr;
    logic        store_Enable, mem_Enable, writen_en, load_signal;

    dec_t  exp_q[$];
    string name_q[$];
    int    compared = 0;
    int    mismatched = 0;

    instruction_decoder dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .instruction(instruction),
        .RegisterA(RegisterA), .RegisterB(RegisterB), .WW(WW), .operation(operation),
        .arithmatic_RD(arithmatic_RD), .HDU_A(HDU_A), .HDU_B(HDU_B), .BR(BR),
        .Branch_immediate(Branch_immediate), .MEM_addr(MEM_addr),
        .store_Enable(store_Enable), .mem_Enable(mem_Enable),
        .writen_en(writen_en), .load_signal(load_signal)
    );

    always #5 clk = ~clk;

    function automatic dec_t exp_r(logic [4:0] ra, logic [4:0] rb, logic [4:0] w,
                                   logic [5:0] func, logic [4:0] rd);
        dec_t e = '0;
        e.reg_a = ra; e.hdu_a = ra; e.reg_b = rb; e.hdu_b = rb;
        e.ww = w; e.operation = func; e.rd = rd; e.wr_en = 1'b1;
        return e;
    endfunction

    function automatic dec_t exp_ld(logic [4:0] rd, logic [15:0] addr);
        dec_t e = '0;
        e.rd = rd; e.mem_addr = addr; e.mem_en = 1'b1; e.wr_en = 1'b1; e.load = 1'b1;
        return e;
    endfunction

    function automatic dec_t exp_st(logic [4:0] ra, logic [15:0] addr);
        dec_t e = '0;
        e.reg_a = ra; e.hdu_a = ra; e.mem_addr = addr; e.mem_en = 1'b1; e.store_en = 1'b1;
        return e;
    endfunction

    function automatic dec_t exp_br(logic [4:0] ra, logic [1:0] br, logic [15:0] imm);
        dec_t e = '0;
        e.reg_a = ra; e.hdu_a = ra; e.br = br; e.br_imm = imm;
        return e;
    endfunction

    task automatic expect_out(string name, dec_t e);
        name_q.push_back(name);
        exp_q.push_back(e);
    endtask

    task automatic step(string name, logic [31:0] instr, logic s, logic f, dec_t e);
        @(negedge clk);
        instruction = instr;
        stall = s;
        flush = f;
        expect_out(name, e);
    endtask

    // Monitor: one pending expectation is consumed per clock edge or reset assertion.
    initial begin
        dec_t  act;
        dec_t  e;
        string n;
        forever begin
            @(posedge clk or posedge reset);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                act.reg_a = RegisterA;     act.reg_b = RegisterB;   act.ww = WW;
                act.operation = operation; act.rd = arithmatic_RD;
                act.hdu_a = HDU_A;         act.hdu_b = HDU_B;       act.br = BR;
                act.br_imm = Branch_immediate; act.mem_addr = MEM_addr;
                act.store_en = store_Enable;   act.mem_en = mem_Enable;
                act.wr_en = writen_en;         act.load = load_signal;
                compared++;
                if (act !== e) begin
                    mismatched++;
                    $display("FAIL %s: got %h required %h", n, act, e);
                end
            end
        end
    end

    initial begin
        dec_t r1;
        dec_t zero;
        zero = '0;
        r1 = exp_r(5'b10101, 5'b00101, 5'b00011, 6'b000010, 5'b11010);

        // Reset state, checked right after the asynchronous assertion.
        #1;
        expect_out("reset_async", zero);
        reset = 1'b1;
        @(negedge clk);
        expect_out("reset_hold", zero);
        @(negedge clk);
        reset = 1'b0;
        instruction = 32'b101010_11010_10101_00101_00011_000010;
        expect_out("rtype", r1);

        step("vbez",   32'b100010_11011_00000_1010100011000010, 1'b0, 1'b0,
             exp_br(5'b11011, 2'b01, 16'hA8C2));
        step("vbnez",  32'b100011_11001_00000_1110100011000010, 1'b0, 1'b0,
             exp_br(5'b11001, 2'b10, 16'hE8C2));
        step("vsd",    32'b100001_11111_00000_1110100011000010, 1'b0, 1'b0,
             exp_st(5'b11111, 16'hE8C2));
        step("vld",    32'b100000_11110_00000_1110100011000010, 1'b0, 1'b0,
             exp_ld(5'b11110, 16'hE8C2));
        step("vnop",   32'hF000_0000, 1'b0, 1'b0, zero);
        step("rtype_r0", 32'b101010_00000_00000_11111_10101_111111, 1'b0, 1'b0,
             exp_r(5'b00000, 5'b11111, 5'b10101, 6'b111111, 5'b00000));
        step("undef_op0", 32'h03FF_FFFF, 1'b0, 1'b0, zero);
        step("vld_ignores_ra", 32'b100000_00001_10101_0001001000110100, 1'b0, 1'b0,
             exp_ld(5'b00001, 16'h1234));
        step("undef_op2b", 32'b101011_11111_11111_1111111111111111, 1'b0, 1'b0, zero);

        // Stall holds the previous decode while the incoming word changes.
        step("rtype_again", 32'b101010_11010_10101_00101_00011_000010, 1'b0, 1'b0, r1);
        step("stall_hold1", 32'b100010_11011_00000_1010100011000010, 1'b1, 1'b0, r1);
        step("stall_hold2", 32'b100001_11111_00000_1110100011000010, 1'b1, 1'b0, r1);
        step("stall_flush", 32'b100000_11110_00000_1110100011000010, 1'b1, 1'b1, zero);
        step("resume_vsd",  32'b100001_11111_00000_1110100011000010, 1'b0, 1'b0,
             exp_st(5'b11111, 16'hE8C2));
        step("flush_only",  32'b101010_11010_10101_00101_00011_000010, 1'b0, 1'b1, zero);
        step("stall_zero",  32'b101010_11010_10101_00101_00011_000010, 1'b1, 1'b0, zero);

        // Reset asserted mid-cycle with R-type outputs present.
        step("pre_reset", 32'b101010_11010_10101_00101_00011_000010, 1'b0, 1'b0, r1);
        @(negedge clk);
        expect_out("reset_midstream", zero);
        #2;
        reset = 1'b1;
        @(negedge clk);
        expect_out("reset_held_edge", zero);
        @(negedge clk);
        reset = 1'b0;
        instruction = 32'b100011_11001_00000_1110100011000010;
        expect_out("after_reset", exp_br(5'b11001, 2'b10, 16'hE8C2));

        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
